// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - 1-write/2-read register file with per-register pending flags
// Define RF_BYPASS_EN to forward same-cycle write data to a matching read.
module multiport_register_file #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_a,
  output logic              rd_valid_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DEPTH-1:0]  pending
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rd_res_t;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_hit;
  logic              rsv_hit;
  rd_res_t           rd_a;
  rd_res_t           rd_b;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  // Reads see the pre-edge pending flags and register contents; a blocked
  // read leaves valid low so the output data register holds.
  function automatic rd_res_t read_port(input logic en, input logic [ADDR_W-1:0] addr);
    rd_res_t r;
    r = '0;
    if (en) begin
      if (!in_range(addr)) begin
        r.valid = 1'b1;
      end
`ifdef RF_BYPASS_EN
      else if (wr_hit && (wr_addr == addr)) begin
        r.valid = 1'b1;
        r.data  = wr_data;
      end
`endif
      else if (!pending[addr]) begin
        r.valid = 1'b1;
        r.data  = regs[addr];
      end
    end
    return r;
  endfunction

  always_comb begin
    wr_hit  = wr_en && in_range(wr_addr);
    rsv_hit = rsv_en && in_range(rsv_addr);
    rd_a    = read_port(rd_en_a, rd_addr_a);
    rd_b    = read_port(rd_en_b, rd_addr_b);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pending    <= '0;
      rd_data_a  <= '0;
      rd_data_b  <= '0;
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
    end else begin
      if (wr_hit) begin
        regs[wr_addr]    <= wr_data;
        pending[wr_addr] <= 1'b0;
      end
      // Later assignment lets a same-index reserve win over the write's clear.
      if (rsv_hit) begin
        pending[rsv_addr] <= 1'b1;
      end
      rd_valid_a <= rd_a.valid;
      rd_valid_b <= rd_b.valid;
      if (rd_a.valid) begin
        rd_data_a <= rd_a.data;
      end
      if (rd_b.valid) begin
        rd_data_b <= rd_b.data;
      end
    end
  end

endmodule
